// File: rtl/mem_copier_if.sv
// Copier bus: command/status handshake plus the single-port word memory bus.
// The copier is the master, and the memory/controller side is the slave.
interface mem_copier_if #(parameter int LEN_W = 16);
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             MemWrite;
    logic [31:0]      Adr;
    logic [31:0]      WriteData;
    logic [31:0]      ReadData;

    modport master (
        input  start, src, dst, len, ReadData,
        output busy, done, MemWrite, Adr, WriteData
    );

    modport slave (
        output start, src, dst, len, ReadData,
        input  busy, done, MemWrite, Adr, WriteData
    );
endinterface

// File: rtl/mem_copier.sv
// Word-by-word memory copier: alternates a READ cycle and a WRITE cycle per word
// on a zero-latency shared memory, copying in ascending address order.
module mem_copier #(
    parameter int LEN_W = 16
) (
    input logic          clk,
    input logic          reset,
    mem_copier_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state, state_nx;
    logic [31:0]      src_ptr, dst_ptr, data_reg;
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            data_reg <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    src_ptr <= {bus.src[31:2], 2'b00};
                    dst_ptr <= {bus.dst[31:2], 2'b00};
                    cnt     <= bus.len;
                end
                READ:  data_reg <= bus.ReadData;
                WRITE: begin
                    src_ptr <= src_ptr + 32'd4;
                    dst_ptr <= dst_ptr + 32'd4;
                    cnt     <= cnt - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Adr       = 32'h0;
        bus.WriteData = 32'h0;
        case (state)
            IDLE: if (bus.start) state_nx = (bus.len == '0) ? DONE : READ;
            READ: begin
                bus.busy = 1'b1;
                bus.Adr  = src_ptr;
                state_nx = WRITE;
            end
            WRITE: begin
                bus.busy      = 1'b1;
                bus.Adr       = dst_ptr;
                // A reset landing on a write cycle suppresses that write.
                bus.MemWrite  = ~reset;
                bus.WriteData = data_reg;
                state_nx      = (cnt == LEN_W'(1)) ? DONE : READ;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_copier.sv
// Self-checking bench for mem_copier: vector table plus hand-written corner sequences,
// with a write scoreboard fed by the stimulus and drained by the bus monitor.
module tb_mem_copier;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_copier_if #(.LEN_W(16)) bus ();
    mem_copier #(.LEN_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {logic [31:0] adr, dat;} wr_t;
    typedef struct {
        logic [31:0] src, dst;
        logic [15:0] len;
        logic [31:0] d0, step;
        int          lat;
    } vec_t;

    logic [31:0] mem [256];
    logic        pl_we = 1'b0;
    logic [31:0] pl_adr, pl_dat;
    wr_t         exp_q[$];
    logic [31:0] rd_seen[$];
    wr_t         mon_e;
    int          tests = 0, fails = 0;

    // 1 KB memory aliased over the 32-bit space; single writer process.
    assign bus.ReadData = mem[bus.Adr[9:2]];
    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.Adr[9:2]] <= bus.WriteData;
        else if (pl_we)   mem[pl_adr[9:2]]  <= pl_dat;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if ($isunknown(bus.MemWrite)) begin
            tests++; fails++;
            $display("FAIL memwrite_x: got %b want 0 or 1", bus.MemWrite);
        end else if (bus.MemWrite) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write: got adr %h dat %h want no write", bus.Adr, bus.WriteData);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_adr", bus.Adr, mon_e.adr);
                chk("wr_dat", bus.WriteData, mon_e.dat);
            end
        end else if (bus.busy && !reset) begin
            rd_seen.push_back(bus.Adr);
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_adr = a; pl_dat = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'h0);
        chk({tag, "_done"},  32'(bus.done), 32'h0);
        chk({tag, "_mw"},    32'(bus.MemWrite), 32'h0);
        chk({tag, "_adr"},   bus.Adr, 32'h0);
        chk({tag, "_wdata"}, bus.WriteData, 32'h0);
    endtask

    // Issue one copy and watch a bounded window; poke_k >= 0 fires a stray start then.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int poke_k, input string nm);
        int done_at = -1, busy_cnt = 0, done_cnt = 0;
        rd_seen.delete();
        bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = n;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.src = $urandom; bus.dst = $urandom; bus.len = 16'($urandom);
        for (int k = 0; k < 2 * int'(n) + 4; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == poke_k) begin
                bus.start = 1'b1; bus.src = 32'h300; bus.dst = 32'h340; bus.len = 16'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk({nm, "_done_at"}, 32'(done_at), 32'(2 * int'(n)));
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(2 * int'(n)));
        chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({nm, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vt[4];

    initial begin
        vt[0] = '{src: 32'h40,       dst: 32'h80,  len: 16'd4, d0: 32'h11,        step: 32'h11,    lat: 8};
        vt[1] = '{src: 32'h100,      dst: 32'h200, len: 16'd0, d0: 32'h0,         step: 32'h0,     lat: 0};
        vt[2] = '{src: 32'hFFFFFFFE, dst: 32'h13,  len: 16'd2, d0: 32'hCAFE0001,  step: 32'h10000, lat: 4};
        vt[3] = '{src: 32'h204,      dst: 32'h300, len: 16'd5, d0: 32'hDEAD0000,  step: 32'h101,   lat: 10};

        // Start held high through reset must be ignored.
        reset = 1'b1; bus.start = 1'b1; bus.src = 32'h40; bus.dst = 32'h80; bus.len = 16'd4;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        chk("start_in_reset_busy", 32'(bus.busy), 32'h0);
        chk("start_in_reset_done", 32'(bus.done), 32'h0);

        foreach (vt[v]) begin
            logic [31:0] sb, db;
            sb = {vt[v].src[31:2], 2'b00};
            db = {vt[v].dst[31:2], 2'b00};
            for (int i = 0; i < int'(vt[v].len); i++) begin
                poke(sb + 32'(4 * i), vt[v].d0 + vt[v].step * 32'(i));
                exp_q.push_back('{adr: db + 32'(4 * i), dat: vt[v].d0 + vt[v].step * 32'(i)});
            end
            run_copy(vt[v].src, vt[v].dst, vt[v].len, -1, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_lat", v), 32'(vt[v].lat), 32'(2 * int'(vt[v].len)));
            chk($sformatf("vec%0d_nreads", v), 32'(rd_seen.size()), 32'(vt[v].len));
            for (int i = 0; i < int'(vt[v].len) && i < rd_seen.size(); i++)
                chk($sformatf("vec%0d_rd%0d", v, i), rd_seen[i], sb + 32'(4 * i));
            for (int i = 0; i < int'(vt[v].len); i++)
                chk($sformatf("vec%0d_mem%0d", v, i), mem[(db[9:2] + 8'(i))],
                    vt[v].d0 + vt[v].step * 32'(i));
        end
        // Wrap vector: read addresses must be the aligned, wrapped pair.
        exp_q.delete();

        // Stray start in cycle 3 of a 3-word copy.
        for (int i = 0; i < 3; i++) begin
            poke(32'h20 + 32'(4 * i), 32'hB0B0_0000 + 32'(i));
            exp_q.push_back('{adr: 32'h60 + 32'(4 * i), dat: 32'hB0B0_0000 + 32'(i)});
        end
        run_copy(32'h20, 32'h60, 16'd3, 2, "busy_start");
        for (int i = 0; i < 3; i++)
            chk($sformatf("busy_start_mem%0d", i), mem[8'h18 + 8'(i)], 32'hB0B0_0000 + 32'(i));

        // Overlap with dst > src propagates the first word.
        poke(32'h0, 32'hAAAA_0001);
        poke(32'h4, 32'hBBBB_0002);
        poke(32'h8, 32'hCCCC_0003);
        exp_q.push_back('{adr: 32'h4, dat: 32'hAAAA_0001});
        exp_q.push_back('{adr: 32'h8, dat: 32'hAAAA_0001});
        run_copy(32'h0, 32'h4, 16'd2, -1, "overlap");
        chk("overlap_mem4", mem[1], 32'hAAAA_0001);
        chk("overlap_mem8", mem[2], 32'hAAAA_0001);

        // Reset during the WRITE cycle of word 2.
        for (int i = 0; i < 4; i++) begin
            poke(32'h180 + 32'(4 * i), 32'h7770_0000 + 32'(i));
            poke(32'h1C0 + 32'(4 * i), 32'h5EE0_0000 + 32'(i));
        end
        exp_q.push_back('{adr: 32'h1C0, dat: 32'h7770_0000});
        bus.start = 1'b1; bus.src = 32'h180; bus.dst = 32'h1C0; bus.len = 16'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midop_in_write", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle("midop");
        repeat (10) begin @(posedge clk); #1; end
        chk("midop_idle_busy", 32'(bus.busy), 32'h0);
        chk("midop_q_empty", 32'(exp_q.size()), 32'd0);
        chk("midop_word3", mem[8'h72], 32'h5EE0_0002);
        chk("midop_word4", mem[8'h73], 32'h5EE0_0003);

        // Fresh copy after the aborted one.
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{adr: 32'hC0 + 32'(4 * i), dat: 32'h11 * 32'(i + 1)});
        run_copy(32'h40, 32'hC0, 16'd4, -1, "after_reset");
        for (int i = 0; i < 4; i++)
            chk($sformatf("after_reset_mem%0d", i), mem[8'h30 + 8'(i)], 32'h11 * 32'(i + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_copier.md
MEM_COPIER -- requirements
Module: mem_copier

Interface
REQ-001 Parameter: LEN_W, 16, width of the word-count input and internal counter.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 Port: src  input  32  source byte address of the first word.
REQ-006 Port: dst  input  32  destination byte address of the first word.
REQ-007 Port: len  input  LEN_W  number of 32-bit words to copy.
REQ-008 Port: busy  output  1  high while the copy is in progress (READ or WRITE state).
REQ-009 Port: done  output  1  one-cycle pulse when a copy completes.
REQ-010 Port: MemWrite  output  1  memory write enable; the memory writes on the next clk edge.
REQ-011 Port: Adr  output  32  memory byte address; bits [1:0] are always 0.
REQ-012 Port: WriteData  output  32  memory write data.
REQ-013 Port: ReadData  input  32  combinational read data for the current Adr (zero-latency memory).

Function
REQ-014 The block SHALL be the bus initiator for the word-aligned shared memory: one access per cycle, with reads combinational and writes registered on clk.
REQ-015 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch src_ptr={src[31:2],2'b00}, dst_ptr={dst[31:2],2'b00} and cnt=len.
- If len!=0, it SHALL go to READ.
- If len==0, it SHALL go to DONE.
REQ-017 start SHALL be ignored in READ, WRITE and DONE. src, dst and len SHALL be sampled only on acceptance.
REQ-018 READ SHALL drive Adr=src_ptr and MemWrite=0, capture ReadData into data_reg at the clock edge, and go to WRITE.
REQ-019 WRITE SHALL drive Adr=dst_ptr, MemWrite=1 and WriteData=data_reg, then on the clock edge:
- src_ptr+=4 and dst_ptr+=4, each modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000);
- cnt-=1;
- go to DONE if cnt was 1, otherwise go to READ.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, drive MemWrite=0, and go to IDLE.
REQ-021 busy SHALL be 1 only in READ and WRITE.
REQ-022 In IDLE and DONE the block SHALL drive Adr=0, WriteData=0 and MemWrite=0.
REQ-023 Latency: for len=N>0, accepted at edge t0, done SHALL be high in the cycle after edge t0+2N, i.e. one word per 2 cycles.
REQ-024 For len=0, done SHALL be high in the cycle after acceptance, and no memory write SHALL occur.
REQ-025 Overlapping regions SHALL be copied strictly in ascending address order, word by word, with no forwarding. Where dst>src and the regions overlap, this propagates source data, and that is the defined behaviour.
REQ-026 A copy of len=2^LEN_W-1 SHALL complete without counter overflow.
REQ-027 MemWrite SHALL be asserted only in WRITE and SHALL never be X after reset.

Reset
REQ-028 When reset=1 at a clock edge, the next state SHALL be IDLE regardless of current state, including mid-copy.
REQ-029 After that edge: busy=0, done=0, MemWrite=0, Adr=0 and WriteData=0. src_ptr, dst_ptr, cnt and data_reg SHALL be cleared to 0.
REQ-030 A write in progress SHALL NOT be completed or retried after reset. Memory contents already written are left as is.
REQ-031 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-032 Basic copy: mem[0x40..0x4C]=0x11,0x22,0x33,0x44; start with src=0x40, dst=0x80, len=4.
- Required: mem[0x80..0x8C]=0x11,0x22,0x33,0x44.
- Required: done pulses once, 8 cycles after acceptance, and busy is high for exactly 8 cycles.
REQ-033 Zero length: start with len=0.
- Required: done is high the next cycle, busy stays 0, and MemWrite is never asserted.
REQ-034 Unaligned and wrap: src=0xFFFFFFFE, dst=0x13, len=2.
- Required read addresses: 0xFFFFFFFC then 0x00000000.
- Required write addresses: 0x10 then 0x14.
REQ-035 Start while busy: second start with different src/dst in cycle 3 of a len=3 copy.
- Required: the second start is ignored and the original 3 words are copied unchanged.
REQ-036 Reset mid-op: assert reset in WRITE of word 2 of a len=4 copy.
- Required: the next cycle shows MemWrite=0, busy=0, done=0 and Adr=0.
- Required: words 3 and 4 are never written, and a new copy then runs correctly.
REQ-037 Overlap: mem[0x0..0x8]=A,B,C; src=0x0, dst=0x4, len=2.
- Required: mem[0x4]=A and mem[0x8]=A.
